// File: rtl/gfx_renderer_zfifo_if.sv
// Pixel stream and render-bus bundle for the gfx256 render back end.
// Signal suffixes are from the renderer's point of view.
interface gfx_renderer_zfifo_if #(
    parameter int point_width = 16,
    parameter int BUS_WIDTH   = 256
);
    logic                   pix_valid_i;
    logic                   pix_ready_o;
    logic [point_width-1:0] pixel_x_i;
    logic [point_width-1:0] pixel_y_i;
    logic [point_width-1:0] pixel_z_i;
    logic [31:0]            color_i;

    logic                   req_o;
    logic                   we_o;
    logic [31:0]            render_addr_o;
    logic [BUS_WIDTH/8-1:0] render_sel_o;
    logic [BUS_WIDTH-1:0]   render_dat_o;
    logic [BUS_WIDTH-1:0]   render_dat_i;
    logic                   ack_i;

    modport master (
        input  pix_valid_i, pixel_x_i, pixel_y_i, pixel_z_i, color_i,
        input  render_dat_i, ack_i,
        output pix_ready_o, req_o, we_o, render_addr_o, render_sel_o, render_dat_o
    );

    modport slave (
        output pix_valid_i, pixel_x_i, pixel_y_i, pixel_z_i, color_i,
        output render_dat_i, ack_i,
        input  pix_ready_o, req_o, we_o, render_addr_o, render_sel_o, render_dat_o
    );
endinterface

// File: rtl/gfx_renderer_zfifo.sv
// Pixel render back end: buffers rasterised pixels, computes colour/z addresses,
// runs an optional read-compare depth test, then issues colour and z bus writes.
module gfx_renderer_zfifo #(
    parameter int point_width = 16,
    parameter int BUS_WIDTH   = 256,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [31:0]            target_base_i,
    input  logic [31:0]            zbuffer_base_i,
    input  logic [point_width-1:0] target_size_x_i,
    input  logic [1:0]             color_depth_i,
    input  logic                   zbuffer_enable_i,
    input  logic [1:0]             zfunc_i,
    gfx_renderer_zfifo_if.master   bus,
    output logic                   ack_o,
    output logic                   busy_o,
    output logic [31:0]            zfail_cnt_o
);
    localparam int SEL_W = BUS_WIDTH / 8;
    localparam int LW    = $clog2(SEL_W);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int EW    = 3 * point_width + 32;
    localparam logic [31:0] LANE_MASK = 32'(SEL_W - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CALC1 = 3'd1;
    localparam logic [2:0] S_CALC2 = 3'd2;
    localparam logic [2:0] S_ZRD   = 3'd3;
    localparam logic [2:0] S_ZCMP  = 3'd4;
    localparam logic [2:0] S_WPIX  = 3'd5;
    localparam logic [2:0] S_WZ    = 3'd6;

    function automatic logic [31:0] ext32(input logic [point_width-1:0] v);
        ext32 = 32'(v);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        sat_inc = (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [1:0] bpp_shift(input logic [1:0] depth);
        bpp_shift = (depth == 2'b00) ? 2'd0 : (depth == 2'b01) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [3:0] pix_ones(input logic [1:0] depth);
        pix_ones = (depth == 2'b00) ? 4'b0001 : (depth == 2'b01) ? 4'b0011 : 4'b1111;
    endfunction

    // The pixel is replicated at its own width so the selected lanes always carry it.
    function automatic logic [BUS_WIDTH-1:0] rep_color(input logic [1:0] depth, input logic [31:0] c);
        case (depth)
            2'b00:   rep_color = {(BUS_WIDTH/8){c[7:0]}};
            2'b01:   rep_color = {(BUS_WIDTH/16){c[15:0]}};
            default: rep_color = {(BUS_WIDTH/32){c}};
        endcase
    endfunction

    logic [EW-1:0]          fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             state_q, state_d;
    logic                   push, pop;
    logic [EW-1:0]          head;

    logic [point_width-1:0] px_q, px_d, py_q, py_d, pz_q, pz_d, sx_q, sx_d;
    logic [31:0]            pc_q, pc_d, tbase_q, tbase_d, zbase_q, zbase_d;
    logic [1:0]             cdepth_q, cdepth_d, zfunc_q, zfunc_d;
    logic                   zen_q, zen_d;

    logic [31:0]            prod_q, prod_d, caddr_q, caddr_d, zaddr_q, zaddr_d;
    logic [SEL_W-1:0]       csel_q, csel_d, zsel_q, zsel_d;
    logic [BUS_WIDTH-1:0]   cdat_q, cdat_d, zdat_q, zdat_d;
    logic [LW-1:0]          zlane_q, zlane_d;
    logic [15:0]            zstored_q, zstored_d;

    logic                   req_q, req_d, we_q, we_d, ack_q, ack_d;
    logic [31:0]            addr_q, addr_d, zfail_q, zfail_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [BUS_WIDTH-1:0]   dat_q, dat_d;

    logic [31:0]            lin, coff, zoff;
    logic [15:0]            pz16, zrd;
    logic                   zpass;

    assign bus.pix_ready_o = (cnt_q != CW'(FIFO_DEPTH));
    assign push   = bus.pix_valid_i & bus.pix_ready_o;
    assign pop    = (state_q == S_IDLE) && (cnt_q != '0);
    assign head   = fifo_mem_q[rptr_q];
    assign busy_o = (cnt_q != '0) || (state_q != S_IDLE);

    assign lin  = prod_q + ext32(px_q);
    assign coff = lin << bpp_shift(cdepth_q);
    assign zoff = lin << 1;
    assign pz16 = 16'(pz_q);
    assign zrd  = 16'(bus.render_dat_i >> {zlane_q, 3'b000});

    always_comb begin
        case (zfunc_q)
            2'b00:   zpass = 1'b1;
            2'b01:   zpass = (pz16 < zstored_q);
            2'b10:   zpass = (pz16 <= zstored_q);
            default: zpass = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(push) - CW'(pop);
        wptr_d  = wptr_q + AW'(push);
        rptr_d  = rptr_q + AW'(pop);
        {px_d, py_d, pz_d, pc_d} = {px_q, py_q, pz_q, pc_q};
        {tbase_d, zbase_d, sx_d} = {tbase_q, zbase_q, sx_q};
        {cdepth_d, zen_d, zfunc_d} = {cdepth_q, zen_q, zfunc_q};
        prod_d    = prod_q;
        caddr_d   = caddr_q;
        zaddr_d   = zaddr_q;
        csel_d    = csel_q;
        zsel_d    = zsel_q;
        cdat_d    = cdat_q;
        zdat_d    = zdat_q;
        zlane_d   = zlane_q;
        zstored_d = zstored_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        dat_d     = dat_q;
        ack_d     = 1'b0;
        zfail_d   = zfail_q;

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    {px_d, py_d, pz_d, pc_d} = head;
                    {tbase_d, zbase_d, sx_d} = {target_base_i, zbuffer_base_i, target_size_x_i};
                    {cdepth_d, zen_d, zfunc_d} = {color_depth_i, zbuffer_enable_i, zfunc_i};
                    state_d = S_CALC1;
                end
            end
            // Stage 1: registered row multiply.
            S_CALC1: begin
                prod_d  = ext32(py_q) * ext32(sx_q);
                state_d = S_CALC2;
            end
            // Stage 2: byte offsets to bus-aligned addresses, lane selects and data.
            S_CALC2: begin
                caddr_d = (tbase_q + coff) & ~LANE_MASK;
                zaddr_d = (zbase_q + zoff) & ~LANE_MASK;
                csel_d  = SEL_W'(pix_ones(cdepth_q)) << coff[LW-1:0];
                zsel_d  = SEL_W'(2'b11) << zoff[LW-1:0];
                zlane_d = zoff[LW-1:0];
                cdat_d  = rep_color(cdepth_q, pc_q);
                zdat_d  = {(BUS_WIDTH/16){pz16}};
                state_d = zen_q ? S_ZRD : S_WPIX;
            end
            S_ZRD: begin
                if (!req_q) begin
                    {req_d, we_d, addr_d, sel_d} = {1'b1, 1'b0, zaddr_q, zsel_q};
                end else if (bus.ack_i) begin
                    req_d     = 1'b0;
                    zstored_d = zrd;
                    state_d   = S_ZCMP;
                end
            end
            S_ZCMP: begin
                if (zpass) begin
                    state_d = S_WPIX;
                end else begin
                    zfail_d = sat_inc(zfail_q);
                    ack_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WPIX: begin
                if (!req_q) begin
                    {req_d, we_d, addr_d, sel_d, dat_d} = {1'b1, 1'b1, caddr_q, csel_q, cdat_q};
                end else if (bus.ack_i) begin
                    req_d   = 1'b0;
                    ack_d   = ~zen_q;
                    state_d = zen_q ? S_WZ : S_IDLE;
                end
            end
            S_WZ: begin
                if (!req_q) begin
                    {req_d, we_d, addr_d, sel_d, dat_d} = {1'b1, 1'b1, zaddr_q, zsel_q, zdat_q};
                end else if (bus.ack_i) begin
                    req_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wptr_q] <= {bus.pixel_x_i, bus.pixel_y_i, bus.pixel_z_i, bus.color_i};
        end
        {px_q, py_q, pz_q, pc_q}    <= {px_d, py_d, pz_d, pc_d};
        {tbase_q, zbase_q, sx_q}    <= {tbase_d, zbase_d, sx_d};
        {cdepth_q, zen_q, zfunc_q}  <= {cdepth_d, zen_d, zfunc_d};
        prod_q    <= prod_d;
        caddr_q   <= caddr_d;
        zaddr_q   <= zaddr_d;
        csel_q    <= csel_d;
        zsel_q    <= zsel_d;
        cdat_q    <= cdat_d;
        zdat_q    <= zdat_d;
        zlane_q   <= zlane_d;
        zstored_q <= zstored_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            zfail_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            zfail_q <= zfail_d;
        end
    end

    assign bus.req_o         = req_q;
    assign bus.we_o          = we_q;
    assign bus.render_addr_o = addr_q;
    assign bus.render_sel_o  = sel_q;
    assign bus.render_dat_o  = dat_q;
    assign ack_o             = ack_q;
    assign zfail_cnt_o       = zfail_q;
endmodule

// File: tb/tb_gfx_renderer_zfifo.sv
// Directed bench for gfx_renderer_zfifo: the bench plays the bus slave and checks
// every request against hand-computed addresses, lane selects and data.
module tb_gfx_renderer_zfifo;
    localparam int PW = 16;
    localparam int BW = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] tbase, zbase;
    logic [15:0] sx;
    logic [1:0]  cdepth, zfunc;
    logic        zen;
    logic        ack_o, busy_o;
    logic [31:0] zfail;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gfx_renderer_zfifo_if #(.point_width(PW), .BUS_WIDTH(BW)) bus ();

    gfx_renderer_zfifo #(.point_width(PW), .BUS_WIDTH(BW), .FIFO_DEPTH(4)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .target_base_i    (tbase),
        .zbuffer_base_i   (zbase),
        .target_size_x_i  (sx),
        .color_depth_i    (cdepth),
        .zbuffer_enable_i (zen),
        .zfunc_i          (zfunc),
        .bus              (bus),
        .ack_o            (ack_o),
        .busy_o           (busy_o),
        .zfail_cnt_o      (zfail)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_pix(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                            input logic [31:0] c);
        int n = 0;
        bus.pix_valid_i = 1'b1;
        bus.pixel_x_i   = x;
        bus.pixel_y_i   = y;
        bus.pixel_z_i   = z;
        bus.color_i     = c;
        while (!bus.pix_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", bus.pix_ready_o, 1'b1);
        @(negedge clk);
        bus.pix_valid_i = 1'b0;
    endtask

    task automatic serve(input string tag, input logic exp_we, input logic [31:0] exp_addr,
                         input logic [31:0] exp_sel, input logic chk_dat, input logic [255:0] exp_dat,
                         input logic [255:0] rdata, input logic exp_ack);
        int n = 0;
        while (!bus.req_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req"}, bus.req_o, 1'b1);
        chk({tag, "_we"}, bus.we_o, exp_we);
        chk({tag, "_addr"}, bus.render_addr_o, exp_addr);
        chk({tag, "_sel"}, bus.render_sel_o, exp_sel);
        if (chk_dat) chk({tag, "_dat"}, bus.render_dat_o, exp_dat);
        bus.render_dat_i = rdata;
        bus.ack_i        = 1'b1;
        @(negedge clk);
        bus.ack_i = 1'b0;
        chk({tag, "_reqdrop"}, bus.req_o, 1'b0);
        chk({tag, "_acko"}, ack_o, exp_ack);
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        chk({tag, "_ackpulse"}, ack_o, 1'b0);
        chk({tag, "_idle"}, busy_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [255:0] rd;
        logic [31:0]  c;
        int           n;

        rst_n = 1'b0;
        tbase = 32'h1000; zbase = 32'h8000; sx = 16'd640;
        cdepth = 2'b10; zfunc = 2'b00; zen = 1'b0;
        bus.pix_valid_i = 1'b1; bus.pixel_x_i = 16'd1; bus.pixel_y_i = 16'd1;
        bus.pixel_z_i = 16'd1; bus.color_i = 32'h12345678;
        bus.ack_i = 1'b0; bus.render_dat_i = '0;

        // Reset held with a pixel offered
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.pix_ready_o, 1'b1);
        chk("rst_req", bus.req_o, 1'b0);
        chk("rst_zfail", zfail, 32'd0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_acko", ack_o, 1'b0);
        chk("rst_addr", bus.render_addr_o, 32'd0);
        bus.pix_valid_i = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_nopush_busy", busy_o, 1'b0);
        chk("rst_nopush_req", bus.req_o, 1'b0);

        // 32bpp, no z: off 0x140C -> addr 0x2400, lane 12
        push_pix(16'd3, 16'd2, 16'd0, 32'hAABBCCDD);
        chk("c32_busy", busy_o, 1'b1);
        serve("c32", 1'b1, 32'h2400, 32'h0000F000, 1'b1, {8{32'hAABBCCDD}}, '0, 1'b1);
        idle_chk("c32");

        // 16bpp z-less pass: off 0x50A, both lanes 10..11
        cdepth = 2'b01; zen = 1'b1; zfunc = 2'b01;
        push_pix(16'd5, 16'd1, 16'h0100, 32'h00001234);
        rd = '1; rd[80 +: 16] = 16'h0200;
        serve("zl_rd", 1'b0, 32'h8500, 32'h00000C00, 1'b0, '0, rd, 1'b0);
        serve("zl_col", 1'b1, 32'h1500, 32'h00000C00, 1'b1, {16{16'h1234}}, '0, 1'b0);
        serve("zl_z", 1'b1, 32'h8500, 32'h00000C00, 1'b1, {16{16'h0100}}, '0, 1'b1);
        chk("zl_zfail", zfail, 32'd0);
        idle_chk("zl");

        // z-less fail on equal depth at lane 0
        cdepth = 2'b10;
        push_pix(16'd0, 16'd0, 16'h0100, 32'h55667788);
        rd = '1; rd[0 +: 16] = 16'h0100;
        serve("zf_rd", 1'b0, 32'h8000, 32'h00000003, 1'b0, '0, rd, 1'b0);
        @(negedge clk);
        chk("zf_acko", ack_o, 1'b1);
        chk("zf_zfail", zfail, 32'd1);
        chk("zf_noreq", bus.req_o, 1'b0);
        idle_chk("zf");

        // Less-equal passes on equal depth; 8bpp at the top lanes
        cdepth = 2'b00; zfunc = 2'b10;
        push_pix(16'd31, 16'd0, 16'h0100, 32'hAABBCCDD);
        rd = '1; rd[240 +: 16] = 16'h0100;
        serve("le_rd", 1'b0, 32'h8020, 32'hC0000000, 1'b0, '0, rd, 1'b0);
        serve("le_col", 1'b1, 32'h1000, 32'h80000000, 1'b1, {32{8'hDD}}, '0, 1'b0);
        serve("le_z", 1'b1, 32'h8020, 32'hC0000000, 1'b1, {16{16'h0100}}, '0, 1'b1);
        chk("le_zfail", zfail, 32'd1);
        idle_chk("le");

        // Never: rejected even against the farthest stored depth
        cdepth = 2'b10; zfunc = 2'b11;
        push_pix(16'd0, 16'd0, 16'h0000, 32'h0);
        serve("nv_rd", 1'b0, 32'h8000, 32'h00000003, 1'b0, '0, {16{16'hFFFF}}, 1'b0);
        @(negedge clk);
        chk("nv_acko", ack_o, 1'b1);
        chk("nv_zfail", zfail, 32'd2);
        idle_chk("nv");

        // FIFO fill with the bus stalled: one in flight plus four queued
        zen = 1'b0; zfunc = 2'b00;
        for (int i = 0; i < 5; i++) begin
            c = 32'h11111111 * 32'(i + 1);
            push_pix(16'(i), 16'd0, 16'd0, c);
        end
        chk("full_ready", bus.pix_ready_o, 1'b0);
        repeat (3) @(negedge clk);
        chk("full_ready_hold", bus.pix_ready_o, 1'b0);
        chk("full_busy", busy_o, 1'b1);
        for (int i = 0; i < 5; i++) begin
            c = 32'h11111111 * 32'(i + 1);
            serve($sformatf("fifo%0d", i), 1'b1, 32'h1000, 32'h0000000F << (4 * i), 1'b1,
                  {8{c}}, '0, 1'b1);
        end
        idle_chk("fifo");

        // Reset while the z write is on the bus, with another pixel queued
        zen = 1'b1; zfunc = 2'b00;
        push_pix(16'd2, 16'd1, 16'h0500, 32'hCAFEF00D);
        push_pix(16'd7, 16'd7, 16'h0001, 32'h01020304);
        serve("rz_rd", 1'b0, 32'h8500, 32'h00000030, 1'b0, '0, '0, 1'b0);
        serve("rz_col", 1'b1, 32'h1A00, 32'h00000F00, 1'b1, {8{32'hCAFEF00D}}, '0, 1'b0);
        n = 0;
        while (!bus.req_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rz_req", bus.req_o, 1'b1);
        chk("rz_addr", bus.render_addr_o, 32'h8500);
        chk("rz_dat", bus.render_dat_o, {16{16'h0500}});
        rst_n = 1'b0;
        @(negedge clk);
        chk("rz_reqdrop", bus.req_o, 1'b0);
        chk("rz_busy", busy_o, 1'b0);
        chk("rz_acko", ack_o, 1'b0);
        chk("rz_zfail", zfail, 32'd0);
        rst_n = 1'b1;
        bus.ack_i = 1'b1;
        @(negedge clk);
        bus.ack_i = 1'b0;
        chk("stray_ack_acko", ack_o, 1'b0);
        repeat (3) @(negedge clk);
        chk("rz_after_req", bus.req_o, 1'b0);
        chk("rz_after_busy", busy_o, 1'b0);
        chk("rz_after_acko", ack_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/gfx_renderer_zfifo.md
Name: gfx_renderer_zfifo

Overview:
Parametrised pixel-render back end for the gfx256 pipeline. It accepts rasterised pixels through a valid/ready FIFO and computes target and z-buffer addresses for a configurable bus width. It optionally performs a read-compare depth test before writing, then issues colour and z writes to the wishbone master. It replaces the fixed-256-bit, single-pixel, write-only renderer, adding buffering, depth test and statistics.

Parameters:
point_width, 16, coordinate/z width
BUS_WIDTH, 256, memory data width in bits (power of two, 32..512)
FIFO_DEPTH, 4, pixel FIFO entries (power of two, >=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
target_base_i  in  32  colour buffer byte base
zbuffer_base_i  in  32  z buffer byte base
target_size_x_i  in  point_width  row stride in pixels
color_depth_i  in  2  00=8bpp, 01=16bpp, 10/11=32bpp
zbuffer_enable_i  in  1  enable depth test and z write
zfunc_i  in  2  00=always, 01=less, 10=less-equal, 11=never
pix_valid_i  in  1  pixel offered
pix_ready_o  out  1  FIFO not full
pixel_x_i, pixel_y_i, pixel_z_i  in  point_width each  pixel coords/depth
color_i  in  32  pixel colour (LSB-aligned)
req_o  out  1  bus request, held until ack_i
we_o  out  1  1=write, 0=read
render_addr_o  out  32  bus-aligned byte address
render_sel_o  out  BUS_WIDTH/8  byte lanes
render_dat_o  out  BUS_WIDTH  write data
render_dat_i  in  BUS_WIDTH  read data
ack_i  in  1  bus ack
ack_o  out  1  one-cycle pulse per retired pixel (written or discarded)
busy_o  out  1  FIFO non-empty or FSM not IDLE
zfail_cnt_o  out  32  count of depth-rejected pixels

Behaviour:
- Reset (rst_ni=0 at clk edge): FIFO empty, state IDLE; req_o, we_o, ack_o, busy_o = 0; render_addr/sel/dat_o = 0; zfail_cnt_o = 0. Reset mid-transaction drops req_o the next cycle and discards all pending pixels.
- FIFO: push when pix_valid_i & pix_ready_o; pop on the IDLE->CALC transition. Simultaneous push+pop when full is not possible (ready=0). Push and pop in the same cycle when non-empty keeps the count unchanged.
- Address: off = (y*size_x + x) << bpp_shift (0/1/2), 32-bit wrap-around arithmetic. addr = base + off with low log2(BUS_WIDTH/8) bits cleared. lane = off[log2(BUS_WIDTH/8)-1:0]. Colour sel = (1/2/4 ones) << lane; data = color_i replicated across bus, sel masks lanes. Z always 16-bit: z offset uses shift 1 regardless of colour depth.
- Config inputs are sampled at pop; changes mid-pixel do not affect that pixel.
- FSM: IDLE -> CALC when FIFO non-empty. CALC (2 cycles, registered multiply) -> ZRD if zbuffer_enable else WPIX. ZRD: req=1, we=0, z address/sel; on ack_i latch stored z from the lane -> ZCMP. ZCMP (1 cycle): pass = always | (less & z<stored) | (le & z<=stored), unsigned. pass -> WPIX; fail -> zfail_cnt+1 (saturating at all-ones), ack_o=1 -> IDLE. WPIX: req=1, we=1 colour addr/sel/dat; on ack_i -> WZ if zbuffer_enable else ack_o=1 -> IDLE. WZ: req=1, we=1 z addr/sel/dat; on ack_i ack_o=1 -> IDLE.
- req_o rises the cycle after state entry and falls the cycle after ack_i. ack_i outside an active req is ignored.
- Minimum latency without z: pop -> 2 CALC cycles -> req; ack_o the cycle after ack_i. Throughput is one pixel per bus transaction set; IDLE is skipped directly to CALC only via one IDLE cycle (no back-to-back bypass).

Test Plan:
- Reset: hold rst_ni=0 while pix_valid_i=1 -> pix_ready_o=1, req_o=0, zfail_cnt_o=0, no push retained after release.
- 32bpp no-z: base 0x1000, size_x 640, (x=3,y=2), color 0xAABBCCDD, BUS 256 -> addr 0x2400, sel 0x0000F000 (lane 12), one write, ack_o pulse.
- 16bpp z-less pass: stored z 0x0200 returned, pixel_z 0x0100 -> read then colour write then z write (sel 2 lanes), zfail_cnt stays 0.
- z-less fail: stored 0x0100, pixel_z 0x0100 -> read only, no write, ack_o pulse, zfail_cnt=1; repeat with zfunc=10 -> passes.
- FIFO full: push 5 pixels with ack_i stalled, depth 4 -> pix_ready_o=0 after 4th entry in FIFO plus 1 in flight. Release ack -> all 5 retired in order with 5 ack_o pulses.
- Reset mid-WZ with req_o=1 -> req_o=0 next cycle, busy_o=0, no ack_o.
